pwm_capture: RTL and testbench

- Measures the period and high time of an external PWM waveform, the receiving end of the SoC's `pwm_output`.
- Exposes the results as a responder on the iob native bus: valid/address/wdata/wstrb in, rdata/ready out.
- Used in the simulation top and the FPGA top so the tester can check duty-cycle programming in closed loop.

---
 rtl/pwm_capture_pkg.sv | 47 ++++
 rtl/pwm_capture_sync.sv | 38 +++
 rtl/pwm_capture.sv | 165 ++++++++++++++++
 tb/tb_pwm_capture.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared constants for the PWM capture block.
//   - word addresses of the four bus-visible registers
//   - bit positions inside CTRL and STATUS
//   - FSM state encoding (plain 2-bit constants, legacy-compatible)
//   - STATUS word layout as a packed struct plus a packing helper
package pwm_capture_pkg;

    // Register word addresses
    localparam int unsigned REG_CTRL   = 0;
    localparam int unsigned REG_PERIOD = 1;
    localparam int unsigned REG_HIGH   = 2;
    localparam int unsigned REG_STATUS = 3;

    // CTRL bits
    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_CLR_BIT = 1;

    // STATUS bits
    localparam int unsigned STAT_VALID_BIT = 0;
    localparam int unsigned STAT_OVF_BIT   = 1;
    localparam int unsigned STAT_LEVEL_BIT = 2;
    localparam int unsigned STAT_NPER_LSB  = 8;

    // FSM states
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_RISE = 2'd1;
    localparam logic [1:0] ST_MEAS      = 2'd2;

    typedef struct packed {
        logic [7:0] nper;
        logic       level;
        logic       ovf;
        logic       valid;
    } status_t;

    // STATUS word: bits[15:8] NPER, bit2 level, bit1 OVF, bit0 VALID.
    function automatic logic [15:0] pack_status(input status_t s);
        logic [15:0] w;
        w = '0;
        w[STAT_VALID_BIT]                  = s.valid;
        w[STAT_OVF_BIT]                    = s.ovf;
        w[STAT_LEVEL_BIT]                  = s.level;
        w[STAT_NPER_LSB +: 8]              = s.nper;
        return w;
    endfunction

endpackage

// File: rtl/pwm_capture_sync.sv
// pwm_capture_sync: brings the asynchronous PWM input into the clk domain
// and detects its edges.
//   clk    system clock
//   rst    synchronous active-high reset
//   pwm_in asynchronous PWM input
//   level  synchronized level (second flop)
//   rise   one-cycle pulse on a synchronized rising edge
//   fall   one-cycle pulse on a synchronized falling edge
// Rise and fall are both taken from the same s2/s3 pair, so both edges see
// the same latency and measured intervals are exact in clk cycles.
module pwm_capture_sync (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an external PWM waveform
// and exposes the results on an iob native responder port.
//   clk      system clock
//   rst      synchronous active-high reset
//   pwm_in   PWM signal under measurement (asynchronous)
//   valid    bus request
//   address  word address (CTRL, PERIOD, HIGH, STATUS)
//   wdata    write data
//   wstrb    byte strobes; nonzero = write, zero = read
//   rdata    read data, updated together with ready
//   ready    single-cycle acknowledge, one cycle after an accepted request
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pwm_in,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             level, rise, fall;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt, hshadow, period, high, high_hold;
    logic             en, meas_valid, ovf;
    logic [7:0]       nper;

    logic             acc, is_write, is_read, ctrl_wr, clr, en_nxt;
    logic [DATA_W-1:0] rd_val;
    status_t          status;

    pwm_capture_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    // A request is accepted in the valid cycle; the ready cycle itself is
    // never treated as a new request.
    assign acc      = valid & ~ready;
    assign is_write = acc & (|wstrb);
    assign is_read  = acc & ~(|wstrb);
    assign ctrl_wr  = is_write && (address == ADDR_W'(REG_CTRL)) && wstrb[0];
    assign clr      = ctrl_wr & wdata[CTRL_CLR_BIT];
    assign en_nxt   = ctrl_wr ? wdata[CTRL_EN_BIT] : en;

    // Upper write-data bits carry nothing.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, wdata[DATA_W-1:2]};

    always_comb begin
        status       = '0;
        status.valid = meas_valid;
        status.ovf   = ovf;
        status.level = level;
        status.nper  = nper;
    end

    always_comb begin
        rd_val = '0;
        case (address)
            ADDR_W'(REG_CTRL):   rd_val = DATA_W'(en);
            ADDR_W'(REG_PERIOD): rd_val = DATA_W'(period);
            ADDR_W'(REG_HIGH):   rd_val = DATA_W'(high_hold);
            ADDR_W'(REG_STATUS): rd_val = DATA_W'(pack_status(status));
            default:             rd_val = '0;
        endcase
    end

    // Measurement FSM. CLR takes priority over everything in the FSM, so a
    // coincident rise capture or overflow is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            en         <= 1'b0;
            cnt        <= '0;
            hshadow    <= '0;
            period     <= '0;
            high       <= '0;
            meas_valid <= 1'b0;
            ovf        <= 1'b0;
            nper       <= '0;
        end else begin
            en <= en_nxt;
            if (clr) begin
                meas_valid <= 1'b0;
                ovf        <= 1'b0;
                nper       <= '0;
                cnt        <= '0;
                state      <= en_nxt ? ST_WAIT_RISE : ST_IDLE;
            end else if (!en) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        cnt   <= '0;
                        state <= ST_WAIT_RISE;
                    end
                    ST_WAIT_RISE: begin
                        if (rise) begin
                            cnt   <= CNT_ONE;
                            state <= ST_MEAS;
                        end
                    end
                    ST_MEAS: begin
                        if (fall) begin
                            hshadow <= cnt;
                        end
                        if (rise) begin
                            period     <= cnt;
                            high       <= hshadow;
                            meas_valid <= 1'b1;
                            nper       <= nper + 8'd1;
                            cnt        <= CNT_ONE;
                        end else if (cnt == CNT_MAX) begin
                            ovf   <= 1'b1;
                            cnt   <= '0;
                            state <= ST_WAIT_RISE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Bus side. A PERIOD read snapshots HIGH so the following HIGH read
    // belongs to the same measurement as the PERIOD just returned.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready     <= 1'b0;
            rdata     <= '0;
            high_hold <= '0;
        end else begin
            ready <= acc;
            if (acc) begin
                rdata <= rd_val;
            end
            if (is_read && (address == ADDR_W'(REG_PERIOD))) begin
                high_hold <= high;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed and randomized checks of pwm_capture.
// A background generator produces whole PWM periods (high then low, lengths
// in clk cycles); expected register values follow from those lengths.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm_in;
    logic        valid = 1'b0;
    logic [1:0]  address = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] rdata;
    logic        ready;

    int tests = 0;
    int fails = 0;

    // Generator controls: gen_n periods to emit (-1 = forever), gen_high
    // forces the line high.
    int gen_hi = 1;
    int gen_lo = 1;
    int gen_n = 0;
    bit gen_high = 1'b0;
    bit gen_busy = 1'b0;

    pwm_capture #(.DATA_W(32), .ADDR_W(2), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .pwm_in  (pwm_in),
        .valid   (valid),
        .address (address),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .rdata   (rdata),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    initial begin
        int h, l;
        pwm_in = 1'b0;
        forever begin
            if (gen_high) begin
                pwm_in = 1'b1;
                @(negedge clk);
            end else if (gen_n != 0) begin
                gen_busy = 1'b1;
                h = gen_hi;
                l = gen_lo;
                pwm_in = 1'b1;
                repeat (h) @(negedge clk);
                pwm_in = 1'b0;
                repeat (l) @(negedge clk);
                if (gen_n > 0) gen_n--;
                gen_busy = 1'b0;
            end else begin
                pwm_in = 1'b0;
                @(negedge clk);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One request: valid for one cycle, ready expected exactly one cycle later.
    task automatic bus(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd);
        address = a;
        wdata   = d;
        wstrb   = s;
        valid   = 1'b1;
        check("ready_pre", {31'd0, ready}, 32'd0);
        @(posedge clk);
        #1;
        check("ready_ack", {31'd0, ready}, 32'd1);
        rd    = rdata;
        valid = 1'b0;
        wstrb = '0;
        @(posedge clk);
        #1;
        check("ready_pulse", {31'd0, ready}, 32'd0);
    endtask

    task automatic rd_chk(input logic [1:0] a, input string tag, input logic [31:0] exp);
        logic [31:0] v;
        bus(a, 32'd0, 4'h0, v);
        check(tag, v, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] v;
        bus(a, d, 4'hF, v);
    endtask

    task automatic wait_gen(input int budget);
        int k;
        k = 0;
        while (!(gen_n == 0 && !gen_busy) && k < budget) begin
            cycles(1);
            k++;
        end
        check("gen_done_in_time", {31'd0, (k < budget)}, 32'd1);
    endtask

    initial begin
        logic [31:0] v, p, hh;
        int hi, lo, n;

        // Reset
        cycles(2);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        cycles(1);
        rd_chk(2'd0, "rst_ctrl", 32'd0);
        rd_chk(2'd1, "rst_period", 32'd0);
        rd_chk(2'd2, "rst_high", 32'd0);
        rd_chk(2'd3, "rst_status", 32'd0);

        // 3 high / 7 low, six rises -> five captures
        wr(2'd0, 32'd1);
        gen_hi = 3; gen_lo = 7; gen_n = 6;
        wait_gen(200);
        cycles(4);
        rd_chk(2'd1, "p37_period", 32'd10);
        rd_chk(2'd2, "p37_high", 32'd3);
        rd_chk(2'd3, "p37_status", 32'h0501);

        // Coherent PERIOD/HIGH pairs across a duty change
        wr(2'd0, 32'd3);
        gen_hi = 10; gen_lo = 30; gen_n = -1;
        cycles(100);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                gen_hi = 30; gen_lo = 10;
            end
            bus(2'd1, 32'd0, 4'h0, p);
            cycles($urandom_range(0, 15));
            bus(2'd2, 32'd0, 4'h0, hh);
            check("coh_pair_ok", {31'd0, (p == 32'd40 && (hh == 32'd10 || hh == 32'd30))}, 32'd1);
            cycles($urandom_range(0, 25));
        end
        cycles(100);
        rd_chk(2'd1, "coh_period75", 32'd40);
        rd_chk(2'd2, "coh_high75", 32'd30);
        gen_n = 0;
        wait_gen(200);

        // Overflow on a stuck-high line
        wr(2'd0, 32'd3);
        gen_high = 1'b1;
        cycles(300);
        rd_chk(2'd3, "ovf_status", 32'h0006);
        gen_high = 1'b0;
        cycles(10);
        gen_hi = 4; gen_lo = 4; gen_n = 3;
        wait_gen(100);
        cycles(4);
        rd_chk(2'd1, "ovf_period", 32'd8);
        rd_chk(2'd2, "ovf_high", 32'd4);
        rd_chk(2'd3, "ovf_status_kept", 32'h0203);
        wr(2'd0, 32'd3);
        rd_chk(2'd3, "clr_status", 32'h0000);
        rd_chk(2'd1, "clr_period_kept", 32'd8);

        // Disable mid-period, RO write ignored, re-enable
        gen_hi = 10; gen_lo = 10; gen_n = -1;
        cycles(60);
        rd_chk(2'd1, "dis_period", 32'd20);
        cycles($urandom_range(1, 15));
        bus(2'd0, 32'd0, 4'hF, v);
        check("dis_wr_returns_en", v, 32'd1);
        bus(2'd1, 32'hFF, 4'hF, v);
        check("ro_wr_returns", v, 32'd20);
        rd_chk(2'd1, "dis_period_kept", 32'd20);
        bus(2'd3, 32'd0, 4'h0, v);
        check("dis_valid_kept", v & 32'h3, 32'd1);
        rd_chk(2'd0, "dis_ctrl", 32'd0);
        gen_n = 0;
        wait_gen(100);
        wr(2'd0, 32'd2);
        wr(2'd0, 32'd1);
        gen_hi = 6; gen_lo = 6; gen_n = 2;
        wait_gen(100);
        cycles(4);
        rd_chk(2'd1, "reen_period", 32'd12);
        rd_chk(2'd2, "reen_high", 32'd6);
        rd_chk(2'd3, "reen_status", 32'h0101);

        // Randomized periods against the arithmetic model
        for (int t = 0; t < 6; t++) begin
            hi = $urandom_range(1, 60);
            lo = $urandom_range(1, 60);
            n  = $urandom_range(2, 5);
            wr(2'd0, 32'd3);
            gen_hi = hi; gen_lo = lo; gen_n = n;
            wait_gen(800);
            cycles(4);
            rd_chk(2'd1, "rnd_period", 32'(hi + lo));
            rd_chk(2'd2, "rnd_high", 32'(hi));
            rd_chk(2'd3, "rnd_status", 32'(((n - 1) << 8) | 1));
        end

        // Reset during measurement with a pending request
        wr(2'd0, 32'd1);
        gen_hi = 10; gen_lo = 10; gen_n = -1;
        cycles(37);
        address = 2'd1;
        wstrb   = 4'h0;
        valid   = 1'b1;
        rst     = 1'b1;
        cycles(1);
        check("rst_mid_ready", {31'd0, ready}, 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        rst   = 1'b0;
        valid = 1'b0;
        cycles(1);
        check("rst_mid_noack", {31'd0, ready}, 32'd0);
        gen_n = 0;
        wait_gen(100);
        cycles(3);
        rd_chk(2'd0, "post_rst_ctrl", 32'd0);
        rd_chk(2'd1, "post_rst_period", 32'd0);
        rd_chk(2'd2, "post_rst_high", 32'd0);
        rd_chk(2'd3, "post_rst_status", 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
